// File: rtl/mips_test_ctrl.sv
// Load/run sequencer for the MIPS core.
// Streams a program into instruction memory and an initial register image
// into the register file over a valid/ready port while holding the core in
// reset, then releases the core for a programmed number of cycles and
// freezes it so its state can be inspected.
module mips_test_ctrl #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int RF_DEPTH   = 32,
    parameter int CYC_W      = 16,
    localparam int IA_W      = $clog2(IMEM_DEPTH),
    localparam int RA_W      = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              skip_imem,
    input  logic              skip_rf,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [IA_W-1:0]   imem_addr,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_addr,
    output logic [DATA_W-1:0] wdata,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CYC_W-1:0]  cyc_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_IMEM,
        LOAD_RF,
        RUN,
        DONE
    } state_t;

    // Last writable address of each segment; a segment never wraps past it.
    localparam logic [IA_W-1:0] IMEM_LAST = IA_W'(IMEM_DEPTH - 1);
    localparam logic [RA_W-1:0] RF_LAST   = RA_W'(RF_DEPTH - 1);

    state_t            state_q, state_d;
    logic [IA_W-1:0]   imem_cnt_q, imem_cnt_d;
    logic [RA_W-1:0]   rf_cnt_q, rf_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CYC_W-1:0]  run_q, run_d;
    logic              skip_rf_q, skip_rf_d;
    logic              overflow_q, overflow_d;

    // Where the sequence goes once the register load is finished or skipped.
    function automatic state_t after_rf(input logic [CYC_W-1:0] run_v);
        return (run_v != '0) ? RUN : DONE;
    endfunction

    // Where the sequence goes once the instruction load is finished or skipped.
    function automatic state_t after_imem(input logic skip_rf_v,
                                          input logic [CYC_W-1:0] run_v);
        return skip_rf_v ? after_rf(run_v) : LOAD_RF;
    endfunction

    assign wdata     = in_data;
    assign imem_addr = imem_cnt_q;
    assign rf_addr   = rf_cnt_q;
    assign overflow  = overflow_q;
    assign cyc_count = cyc_q;

    // Next-state, counter updates and state-decoded outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        imem_cnt_d = imem_cnt_q;
        rf_cnt_d   = rf_cnt_q;
        cyc_d      = cyc_q;
        run_d      = run_q;
        skip_rf_d  = skip_rf_q;
        overflow_d = overflow_q;
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        rf_we      = 1'b0;
        cpu_en     = 1'b0;
        cpu_rst    = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    cpu_rst = 1'b0;
                    done    = 1'b1;
                end
                if (start) begin
                    imem_cnt_d = '0;
                    rf_cnt_d   = '0;
                    cyc_d      = '0;
                    overflow_d = 1'b0;
                    run_d      = run_cycles;
                    skip_rf_d  = skip_rf;
                    state_d    = skip_imem ? after_imem(skip_rf, run_cycles) : LOAD_IMEM;
                end
            end
            LOAD_IMEM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                imem_we  = in_valid;
                if (in_valid) begin
                    if (imem_cnt_q != IMEM_LAST) imem_cnt_d = imem_cnt_q + IA_W'(1);
                    if (in_last || imem_cnt_q == IMEM_LAST) state_d = after_imem(skip_rf_q, run_q);
                    if (!in_last && imem_cnt_q == IMEM_LAST) overflow_d = 1'b1;
                end
            end
            LOAD_RF: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                rf_we    = in_valid;
                if (in_valid) begin
                    if (rf_cnt_q != RF_LAST) rf_cnt_d = rf_cnt_q + RA_W'(1);
                    if (in_last || rf_cnt_q == RF_LAST) state_d = after_rf(run_q);
                    if (!in_last && rf_cnt_q == RF_LAST) overflow_d = 1'b1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                cpu_rst = 1'b0;
                cpu_en  = 1'b1;
                // The final enabled cycle leaves cyc_count at run_cycles-1.
                if (cyc_q == run_q - CYC_W'(1)) state_d = DONE;
                else                             cyc_d   = cyc_q + CYC_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything except a write already strobed this cycle.
        if (abort) begin
            state_d    = IDLE;
            imem_cnt_d = imem_cnt_q;
            rf_cnt_d   = rf_cnt_q;
            cyc_d      = cyc_q;
            run_d      = run_q;
            skip_rf_d  = skip_rf_q;
            overflow_d = overflow_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            imem_cnt_q <= '0;
            rf_cnt_q   <= '0;
            cyc_q      <= '0;
            run_q      <= '0;
            skip_rf_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            imem_cnt_q <= imem_cnt_d;
            rf_cnt_q   <= rf_cnt_d;
            cyc_q      <= cyc_d;
            run_q      <= run_d;
            skip_rf_q  <= skip_rf_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mips_test_ctrl.sv
// Self-checking bench for mips_test_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model that tracks the remaining segments of a sequence.
module tb_mips_test_ctrl;

    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 8;
    localparam int RF_DEPTH   = 4;
    localparam int CYC_W      = 8;
    localparam int IA_W       = $clog2(IMEM_DEPTH);
    localparam int RA_W       = $clog2(RF_DEPTH);

    // Segment codes used by the model's plan queue.
    localparam int SEG_IMEM = 0;
    localparam int SEG_RF   = 1;
    localparam int SEG_RUN  = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              skip_imem;
    logic              skip_rf;
    logic [CYC_W-1:0]  run_cycles;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              imem_we;
    logic [IA_W-1:0]   imem_addr;
    logic              rf_we;
    logic [RA_W-1:0]   rf_addr;
    logic [DATA_W-1:0] wdata;
    logic              cpu_rst;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [CYC_W-1:0]  cyc_count;

    mips_test_ctrl #(
        .DATA_W(DATA_W), .IMEM_DEPTH(IMEM_DEPTH), .RF_DEPTH(RF_DEPTH), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .skip_imem(skip_imem), .skip_rf(skip_rf), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .rf_we(rf_we), .rf_addr(rf_addr),
        .wdata(wdata), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .busy(busy), .done(done),
        .overflow(overflow), .cyc_count(cyc_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // plan holds the segments still to perform; empty means not busy.
    int plan[$];
    bit m_done = 0;
    bit m_ovf  = 0;
    int m_n    = 0;   // beats written in the current load segment
    int m_k    = 0;   // enabled cycles executed in the current run
    int m_run  = 0;   // run length captured at start

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plan.delete();
            m_done = 0; m_ovf = 0; m_n = 0; m_k = 0; m_run = 0;
        end else if (abort) begin
            plan.delete();
            m_done = 0;
        end else if (plan.size() == 0) begin
            if (start) begin
                m_n = 0; m_k = 0; m_ovf = 0;
                m_run = int'(run_cycles);
                if (!skip_imem) plan.push_back(SEG_IMEM);
                if (!skip_rf) plan.push_back(SEG_RF);
                if (m_run != 0) plan.push_back(SEG_RUN);
                m_done = (plan.size() == 0);
            end
        end else if (plan[0] == SEG_RUN) begin
            m_k++;
            if (m_k == m_run) begin
                plan.pop_front();
                m_done = 1;
            end
        end else if (in_valid) begin
            int depth;
            depth = (plan[0] == SEG_IMEM) ? IMEM_DEPTH : RF_DEPTH;
            m_n++;
            if (in_last || m_n == depth) begin
                if (!in_last) m_ovf = 1;
                plan.pop_front();
                m_n = 0;
                if (plan.size() == 0) m_done = 1;
            end
        end
    end

    // Write/enable log used by the directed scenarios.
    int imem_log[$];
    int rf_log[$];
    int en_cnt = 0;

    // Compare process: DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        int  seg;
        int  exp_cyc;
        seg     = (plan.size() != 0) ? plan[0] : -1;
        exp_cyc = (m_run != 0 && m_k == m_run) ? m_run - 1 : m_k;
        check("busy",      busy,      (seg >= 0));
        check("done",      done,      m_done);
        check("in_ready",  in_ready,  (seg == SEG_IMEM || seg == SEG_RF));
        check("cpu_en",    cpu_en,    (seg == SEG_RUN));
        check("cpu_rst",   cpu_rst,   !(seg == SEG_RUN || m_done));
        check("overflow",  overflow,  m_ovf);
        check("cyc_count", cyc_count, exp_cyc);
        check("imem_we",   imem_we,   (seg == SEG_IMEM && in_valid));
        check("rf_we",     rf_we,     (seg == SEG_RF && in_valid));
        if (seg == SEG_IMEM && in_valid) begin
            check("imem_addr", imem_addr, m_n);
            check("wdata_i",   wdata,     in_data);
        end
        if (seg == SEG_RF && in_valid) begin
            check("rf_addr", rf_addr, m_n);
            check("wdata_r", wdata,   in_data);
        end
        if (imem_we) imem_log.push_back(int'(imem_addr));
        if (rf_we)   rf_log.push_back(int'(rf_addr));
        if (cpu_en)  en_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        imem_log.delete();
        rf_log.delete();
        en_cnt = 0;
    endtask

    task automatic do_start(input logic si, input logic sr, input int rc);
        start = 1'b1; skip_imem = si; skip_rf = sr; run_cycles = CYC_W'(rc);
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic last);
        in_valid = 1'b1; in_last = last; in_data = $urandom;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst"},  cpu_rst,   1'b1);
        check({tag, "_cpu_en"},   cpu_en,    1'b0);
        check({tag, "_in_ready"}, in_ready,  1'b0);
        check({tag, "_done"},     done,      1'b0);
        check({tag, "_busy"},     busy,      1'b0);
        check({tag, "_overflow"}, overflow,  1'b0);
        check({tag, "_cyc"},      cyc_count, 0);
    endtask

    task automatic check_log(input string tag, input int log_q[$], input int n);
        check({tag, "_n"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            check($sformatf("%s_addr%0d", tag, i), log_q[i], i);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; skip_imem = 1'b0; skip_rf = 1'b0;
        run_cycles = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        #1 rst = 1'b0;
        #2 check_reset_values("por");
        tick();
        rst = 1'b1;
        tick();

        // Full sequence: 3 imem beats, 2 rf beats, 3 run cycles.
        clear_logs();
        do_start(1'b0, 1'b0, 3);
        beat(1'b0); beat(1'b0); beat(1'b1);
        beat(1'b0); beat(1'b1);
        repeat (3) tick();
        check_log("full_imem", imem_log, 3);
        check_log("full_rf", rf_log, 2);
        check("full_en_cycles", en_cnt, 3);
        check("full_done", done, 1'b1);
        check("full_cyc", cyc_count, 2);
        check("full_ovf", overflow, 1'b0);
        check("full_cpu_rst", cpu_rst, 1'b0);

        // Backpressure gaps during the instruction load.
        clear_logs();
        do_start(1'b0, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); in_last = (i == 4); in_data = $urandom;
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check_log("bp_imem", imem_log, 3);
        check("bp_done", done, 1'b1);

        // Register-file overflow: 5 beats offered, none marked last.
        clear_logs();
        do_start(1'b1, 1'b0, 2);
        in_valid = 1'b1; in_last = 1'b0;
        repeat (4) begin
            in_data = $urandom;
            tick();
        end
        check("ovf_5th_ready", in_ready, 1'b0);
        check("ovf_5th_we", rf_we, 1'b0);
        check("ovf_in_run", cpu_en, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check_log("ovf_rf", rf_log, 4);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_done", done, 1'b1);

        // Both loads skipped, 5 run cycles.
        clear_logs();
        do_start(1'b1, 1'b1, 5);
        repeat (6) tick();
        check("skip_en_cycles", en_cnt, 5);
        check("skip_done", done, 1'b1);

        // Zero run length with both loads skipped goes straight to DONE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("zr_abort_done", done, 1'b0);
        clear_logs();
        do_start(1'b1, 1'b1, 0);
        check("zr_done", done, 1'b1);
        check("zr_busy", busy, 1'b0);
        repeat (3) tick();
        check("zr_en_cycles", en_cnt, 0);

        // Abort during run, with a simultaneous start that must be ignored.
        do_start(1'b1, 1'b1, 10);
        repeat (2) tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_cpu_rst", cpu_rst, 1'b1);
        check("abort_cpu_en", cpu_en, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_cyc", cyc_count, 2);
        tick();
        check("abort_start_ignored", busy, 1'b0);

        // Asynchronous reset in the middle of an instruction load.
        do_start(1'b0, 1'b0, 2);
        beat(1'b0); beat(1'b0);
        #1 rst = 1'b0;
        #1 check_reset_values("midrst");
        tick();
        rst = 1'b1;
        clear_logs();
        do_start(1'b0, 1'b1, 0);
        beat(1'b1);
        check_log("midrst_reload", imem_log, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start      = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 63) == 0);
            skip_imem  = ($urandom_range(0, 2) == 0);
            skip_rf    = ($urandom_range(0, 2) == 0);
            run_cycles = CYC_W'($urandom_range(0, 12));
            in_valid   = $urandom_range(0, 1) == 1;
            in_last    = ($urandom_range(0, 3) == 0);
            in_data    = $urandom;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #2 rst = 1'b1;
            end
            tick();
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_test_ctrl.md
Name: mips_test_ctrl

Overview:
- Parametrised load/run sequencer for the MIPS processor.
- Streams a program into instruction memory and an initial state into the register file over a valid/ready interface, holding the core in reset meanwhile.
- Releases the core for a programmed number of cycles, then freezes it and flags done.
- Replaces hierarchical memory preloading with a synthesizable path usable on silicon/FPGA as well as in simulation.

Parameters:
- DATA_W, 32, width of instruction/register words
- IMEM_DEPTH, 1024, instruction memory depth in words (IA_W = $clog2(IMEM_DEPTH))
- RF_DEPTH, 32, register file depth (RA_W = $clog2(RF_DEPTH))
- CYC_W, 16, width of run-cycle counter

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin sequence; honoured only in IDLE or DONE
- abort  in  1  return to IDLE from any state
- skip_imem  in  1  sampled at start; 1 = skip instruction load
- skip_rf  in  1  sampled at start; 1 = skip register load
- run_cycles  in  CYC_W  sampled at start; core run length in cycles
- in_valid  in  1  load beat valid
- in_ready  out  1  load beat accepted when in_valid & in_ready
- in_data  in  DATA_W  load word
- in_last  in  1  final beat of current segment
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  IA_W  instruction memory write address
- rf_we  out  1  register file write strobe
- rf_addr  out  RA_W  register file write address
- wdata  out  DATA_W  shared write data (= in_data)
- cpu_rst  out  1  active-high reset to core
- cpu_en  out  1  core clock enable
- busy  out  1  state not IDLE/DONE
- done  out  1  run complete
- overflow  out  1  sticky: segment hit depth without in_last
- cyc_count  out  CYC_W  cycles executed in current/last run

Behaviour:
- States: IDLE, LOAD_IMEM, LOAD_RF, RUN, DONE.
- Reset (rst=0, async): state IDLE; cpu_rst=1, cpu_en=0, in_ready=0, done=0, busy=0, overflow=0, cyc_count=0, address counters 0.
- IDLE/DONE + start: clear overflow, cyc_count, both address counters, done.
  - Latch skip_imem, skip_rf, run_cycles.
  - Next state is the first of LOAD_IMEM, LOAD_RF, RUN not skipped; RUN is skipped when run_cycles==0, in which case next state is DONE.
- LOAD_IMEM:
  - in_ready=1.
  - On each handshake, imem_we=1 combinationally in that cycle, imem_addr=current counter, wdata=in_data; counter increments next edge.
  - Exit after the beat with in_last=1.
  - Exit after the beat written at IMEM_DEPTH-1 without in_last; this also sets overflow.
  - Next state per skip/run rules above.
- LOAD_RF: identical rules using rf_we/rf_addr and RF_DEPTH. Address 0 is written like any other; the register file ignores it.
- cpu_rst=1 in IDLE, LOAD_IMEM, LOAD_RF. cpu_rst=0 in RUN and DONE, so the core's state is preserved for inspection.
- RUN:
  - cpu_en=1.
  - cyc_count increments each cycle.
  - When cyc_count reaches run_cycles-1, next state is DONE, so exactly run_cycles enabled cycles occur.
- DONE: cpu_en=0, done=1, cyc_count holds.
- in_ready=0 outside load states. Beats offered then are not consumed and cause no writes.
- start while busy: ignored.
- abort (highest priority, sync): next state IDLE, cpu_en=0, cpu_rst=1. Counters and overflow hold; done cleared. Any in-flight handshake in that cycle still writes.
- start and abort in the same cycle: abort wins.
- busy = state in {LOAD_IMEM, LOAD_RF, RUN}.
- Counters wrap never: exits fire at depth-1. cyc_count compares with full CYC_W width.
- rst asserted mid-sequence: immediate return to reset values. Memory contents are undefined/unchanged (owned by memories).

Test Plan:
- Full sequence: start, run_cycles=3; 3 imem beats (last on 3rd), 2 rf beats -> imem writes at 0,1,2; rf writes at 0,1; cpu_en high exactly 3 cycles; done=1, cyc_count=2, overflow=0.
- Backpressure gaps: in_valid toggled 1,0,1,0,1 in LOAD_IMEM -> exactly 3 writes at consecutive addresses; no write on idle cycles.
- Overflow: RF_DEPTH=4, 5 rf beats without in_last -> writes at 0..3, overflow=1, transition to RUN; 5th beat sees in_ready=0.
- Skips: skip_imem=1, skip_rf=1, run_cycles=5 -> straight to RUN, 5 enabled cycles, done. Separately run_cycles=0 with skip_imem=1, skip_rf=1 -> DONE next cycle, cpu_en never high.
- Abort during RUN at cycle 2 of 10 -> IDLE next edge, cpu_rst=1, cpu_en=0, done=0, cyc_count=2. Start during abort cycle ignored.
- Async reset mid-LOAD_IMEM (rst low between edges) -> outputs take reset values immediately. After rst high, start reloads from address 0.
